// File: rtl/qam4_bit_framer.sv
// Serial-to-symbol framer ahead of the 4-QAM mapper: packs bit pairs (first bit MSB) into a
// small FIFO and releases one symbol per SYM_DIV-clock period on a free-running strobe.
module qam4_bit_framer #(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned SYM_DIV    = 4,
    parameter logic [1:0]  IDLE_SYM   = 2'b00
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          bit_in,
    input  logic                          bit_valid,
    output logic                          bit_ready,
    output logic [1:0]                    sym_bits,
    output logic                          sym_valid,
    output logic                          sym_strobe,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          underflow
);

    localparam int unsigned PW = $clog2(FIFO_DEPTH);
    localparam int unsigned LW = PW + 1;
    localparam int unsigned CW = (SYM_DIV > 1) ? $clog2(SYM_DIV) : 1;
    localparam logic [CW-1:0] CntLast   = CW'(SYM_DIV - 1);
    localparam logic [LW-1:0] LevelFull = LW'(FIFO_DEPTH);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          strobe_q;
    logic          half_q, msb_q, started_q, under_q, valid_q;
    logic [1:0]    sym_q;
    logic [PW-1:0] wptr_q, rptr_q;
    logic [LW-1:0] level_q, level_d;
    logic [1:0]    mem [FIFO_DEPTH];
    logic          accept, push, pop;

    always_comb begin
        cnt_d     = (cnt_q == CntLast) ? '0 : cnt_q + CW'(1);
        // Ready depends on registered state only, so a pop never feeds back combinationally.
        bit_ready = !half_q || (level_q != LevelFull);
        accept    = bit_valid && bit_ready;
        push      = accept && half_q;
        // Pop looks at the pre-edge level: a same-edge push into an empty FIFO is not bypassed.
        pop       = strobe_q && (level_q != '0);
        level_d   = level_q;
        case ({push, pop})
            2'b10:   level_d = level_q + LW'(1);
            2'b01:   level_d = level_q - LW'(1);
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wptr_q] <= {msb_q, bit_in};
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q     <= '0;
            strobe_q  <= 1'b0;
            half_q    <= 1'b0;
            msb_q     <= 1'b0;
            started_q <= 1'b0;
            under_q   <= 1'b0;
            valid_q   <= 1'b0;
            sym_q     <= IDLE_SYM;
            wptr_q    <= '0;
            rptr_q    <= '0;
            level_q   <= '0;
        end else begin
            cnt_q    <= cnt_d;
            // Registered strobe keeps it low in reset even when SYM_DIV is 1.
            strobe_q <= (cnt_d == CntLast);
            level_q  <= level_d;
            if (accept) begin
                if (!half_q) begin
                    msb_q  <= bit_in;
                    half_q <= 1'b1;
                end else begin
                    half_q <= 1'b0;
                    wptr_q <= wptr_q + PW'(1);
                end
            end
            if (strobe_q) begin
                if (pop) begin
                    sym_q     <= mem[rptr_q];
                    valid_q   <= 1'b1;
                    started_q <= 1'b1;
                    rptr_q    <= rptr_q + PW'(1);
                end else begin
                    sym_q   <= IDLE_SYM;
                    valid_q <= 1'b0;
                    if (started_q) begin
                        under_q <= 1'b1;
                    end
                end
            end
        end
    end

    assign sym_bits   = sym_q;
    assign sym_valid  = valid_q;
    assign sym_strobe = strobe_q;
    assign fifo_level = level_q;
    assign underflow  = under_q;

endmodule

// File: tb/tb_qam4_bit_framer.sv
// Randomized bench for qam4_bit_framer against a queue-based behavioural model of the framer.
module tb_qam4_bit_framer;

    localparam int DEPTH = 4;
    localparam int DIV   = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       bit_in = 1'b0;
    logic       bit_valid = 1'b0;
    logic       bit_ready;
    logic [1:0] sym_bits;
    logic       sym_valid;
    logic       sym_strobe;
    logic [2:0] fifo_level;
    logic       underflow;

    qam4_bit_framer #(
        .FIFO_DEPTH(DEPTH),
        .SYM_DIV   (DIV),
        .IDLE_SYM  (2'b00)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .bit_in    (bit_in),
        .bit_valid (bit_valid),
        .bit_ready (bit_ready),
        .sym_bits  (sym_bits),
        .sym_valid (sym_valid),
        .sym_strobe(sym_strobe),
        .fifo_level(fifo_level),
        .underflow (underflow)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Model state: symbols waiting, held half-pair, output registers, edges since release.
    logic [1:0] q[$];
    logic       tx[$];
    logic       m_half, m_msb, m_started, m_under, m_valid, m_acc;
    logic [1:0] m_sym;
    int         m_edges;
    int         max_level;
    int         emitted;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, obs, exp);
        end
    endtask

    task automatic model_clear();
        q.delete();
        m_half    = 1'b0;
        m_msb     = 1'b0;
        m_started = 1'b0;
        m_under   = 1'b0;
        m_valid   = 1'b0;
        m_acc     = 1'b0;
        m_sym     = 2'b00;
        m_edges   = 0;
    endtask

    task automatic compare_all(input string phase);
        check_eq({phase, ".ready"}, bit_ready, (!m_half || q.size() != DEPTH));
        check_eq({phase, ".strobe"}, sym_strobe, ((m_edges + 1) % DIV) == 0);
        check_eq({phase, ".level"}, fifo_level, q.size());
        check_eq({phase, ".sym"}, sym_bits, m_sym);
        check_eq({phase, ".valid"}, sym_valid, m_valid);
        check_eq({phase, ".underflow"}, underflow, m_under);
    endtask

    task automatic tick(input string phase);
        @(posedge clk);
        m_acc = bit_valid && (!m_half || q.size() != DEPTH);
        m_edges++;
        if (m_edges % DIV == 0) begin
            if (q.size() > 0) begin
                m_sym     = q.pop_front();
                m_valid   = 1'b1;
                m_started = 1'b1;
                emitted++;
            end else begin
                m_sym   = 2'b00;
                m_valid = 1'b0;
                if (m_started) m_under = 1'b1;
            end
        end
        if (m_acc) begin
            if (!m_half) begin
                m_msb  = bit_in;
                m_half = 1'b1;
            end else begin
                q.push_back({m_msb, bit_in});
                m_half = 1'b0;
            end
        end
        #1;
        compare_all(phase);
        if (int'(fifo_level) > max_level) max_level = int'(fifo_level);
    endtask

    // Drives bits from tx; a presented bit is held until the model sees it accepted.
    task automatic run(input string phase, input int cycles, input int pct);
        for (int i = 0; i < cycles; i++) begin
            if (!bit_valid && tx.size() > 0 && $urandom_range(99) < pct) begin
                bit_in    = tx.pop_front();
                bit_valid = 1'b1;
            end
            tick(phase);
            if (m_acc) bit_valid = 1'b0;
        end
    endtask

    task automatic do_reset(input string phase);
        reset     = 1'b0;
        bit_valid = 1'b0;
        tx.delete();
        model_clear();
        #1;
        check_eq({phase, ".rst_sym"}, sym_bits, 2'b00);
        check_eq({phase, ".rst_valid"}, sym_valid, 1'b0);
        check_eq({phase, ".rst_strobe"}, sym_strobe, 1'b0);
        check_eq({phase, ".rst_level"}, fifo_level, 0);
        check_eq({phase, ".rst_underflow"}, underflow, 1'b0);
        check_eq({phase, ".rst_ready"}, bit_ready, 1'b1);
        repeat (2) @(posedge clk);
        #3;
        reset = 1'b1;
    endtask

    initial begin
        model_clear();
        max_level = 0;
        emitted   = 0;
        do_reset("init");

        run("idle", 13, 0);

        foreach (tx[i]) tx.delete(i);
        tx = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
        emitted = 0;
        run("pack", 24, 100);
        check_eq("pack.count", emitted, 4);

        max_level = 0;
        for (int i = 0; i < 16; i++) tx.push_back(logic'(i % 2));
        run("bp", 50, 100);
        check_eq("bp.max_level", max_level, DEPTH);

        for (int i = 0; i < 4; i++) tx.push_back(logic'($urandom_range(1)));
        run("uf", 24, 100);
        check_eq("uf.sticky", underflow, 1'b1);
        for (int i = 0; i < 6; i++) tx.push_back(logic'($urandom_range(1)));
        run("resume", 24, 100);

        for (int i = 0; i < 600; i++) tx.push_back(logic'($urandom_range(1)));
        run("rand", 900, 60);

        for (int i = 0; i < 400; i++) tx.push_back(logic'($urandom_range(1)));
        for (int i = 0; i < 200; i++) begin
            if (q.size() == 3 && m_half) break;
            run("prefill", 1, 100);
        end
        #2;
        do_reset("mid");
        tx = '{1'b1, 1'b0};
        emitted = 0;
        run("post", 24, 100);
        check_eq("post.count", emitted, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
